esc_rx_ctrl: RTL and testbench

//   Escape-mode receive controller for the slave lane. Runs on RxClkEsc, sequences ESC_Deserializer by gating EscDeserEn.

---
 rtl/esc_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_esc_rx_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_rx_ctrl.sv
// Escape-mode receive controller for the slave lane: decodes the entry command,
// then runs LPDT byte reception, ULPS hold or trigger reporting until Stop.
module esc_rx_ctrl #(
    parameter logic [7:0] CMD_LPDT  = 8'h87,
    parameter logic [7:0] CMD_ULPS  = 8'h78,
    parameter logic [7:0] CMD_TRIG0 = 8'h46,
    parameter logic [7:0] CMD_TRIG1 = 8'h5D,
    parameter logic [7:0] CMD_TRIG2 = 8'hA2,
    parameter logic [7:0] CMD_TRIG3 = 8'hB9
) (
    input  logic       RxClkEsc,
    input  logic       RstN,
    input  logic       EscEntryDet,
    input  logic       BitStrobe,
    input  logic       StopDet,
    input  logic [7:0] RxEscData,
    output logic       EscDeserEn,
    output logic       RxLpdtEsc,
    output logic       RxUlpsEsc,
    output logic [7:0] RxDataEsc,
    output logic       RxValidEsc,
    output logic [3:0] RxTriggerEsc,
    output logic       ErrEsc,
    output logic       ErrSyncEsc,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CMD       = 3'd1;
    localparam logic [2:0] S_CMD_CHK   = 3'd2;
    localparam logic [2:0] S_LPDT      = 3'd3;
    localparam logic [2:0] S_ULPS      = 3'd4;
    localparam logic [2:0] S_WAIT_STOP = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic       byte_pend;
    logic       byte_pend_nxt;
    logic       shift_en;
    logic       last_bit;
    logic [3:0] trig_hit;
    logic       cmd_lpdt;
    logic       cmd_ulps;
    logic       cmd_unknown;

    // The deserializer shifts on every gated strobe, including one that
    // coincides with StopDet; that bit is simply never consumed.
    assign shift_en   = BitStrobe && ((state == S_CMD) || (state == S_LPDT));
    assign EscDeserEn = shift_en;
    assign last_bit   = shift_en && (bit_cnt == 3'd7);

    assign trig_hit = {RxEscData == CMD_TRIG3, RxEscData == CMD_TRIG2,
                       RxEscData == CMD_TRIG1, RxEscData == CMD_TRIG0};
    assign cmd_lpdt    = (RxEscData == CMD_LPDT);
    assign cmd_ulps    = (RxEscData == CMD_ULPS);
    assign cmd_unknown = !(cmd_lpdt || cmd_ulps || (|trig_hit));

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        byte_pend_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (EscEntryDet) begin
                    state_nxt   = S_CMD;
                    bit_cnt_nxt = 3'd0;
                end
            end
            S_CMD: begin
                if (StopDet) begin
                    state_nxt   = S_IDLE;
                    bit_cnt_nxt = 3'd0;
                end else if (shift_en) begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (last_bit) begin
                        state_nxt = S_CMD_CHK;
                    end
                end
            end
            S_CMD_CHK: begin
                if (StopDet) begin
                    state_nxt = S_IDLE;
                end else if (cmd_lpdt) begin
                    state_nxt = S_LPDT;
                end else if (cmd_ulps) begin
                    state_nxt = S_ULPS;
                end else begin
                    state_nxt = S_WAIT_STOP;
                end
                bit_cnt_nxt = 3'd0;
            end
            S_LPDT: begin
                if (StopDet) begin
                    state_nxt   = S_IDLE;
                    bit_cnt_nxt = 3'd0;
                end else if (shift_en) begin
                    bit_cnt_nxt   = bit_cnt + 3'd1;
                    byte_pend_nxt = last_bit;
                end
            end
            S_ULPS, S_WAIT_STOP: begin
                if (StopDet) begin
                    state_nxt   = S_IDLE;
                    bit_cnt_nxt = 3'd0;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                bit_cnt_nxt = 3'd0;
            end
        endcase
    end

    // byte_pend marks the cycle where the deserializer holds a complete byte.
    always_ff @(posedge RxClkEsc or negedge RstN) begin
        if (!RstN) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            byte_pend  <= 1'b0;
            RxDataEsc  <= 8'h00;
            RxValidEsc <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_pend  <= byte_pend_nxt;
            RxValidEsc <= byte_pend;
            if (byte_pend) begin
                RxDataEsc <= RxEscData;
            end
        end
    end

    assign RxLpdtEsc    = (state == S_LPDT);
    assign RxUlpsEsc    = (state == S_ULPS);
    assign RxTriggerEsc = (state == S_CMD_CHK) ? trig_hit : 4'b0000;
    assign ErrEsc       = (state == S_CMD_CHK) && cmd_unknown;
    assign ErrSyncEsc   = (state == S_LPDT) && StopDet && (bit_cnt != 3'd0);
    assign dbg_state    = state;

endmodule

// File: tb/tb_esc_rx_ctrl.sv
// Bench for esc_rx_ctrl: command table, directed corner sequences and randomized
// escape sessions checked against a per-session byte/pulse model.
module tb_esc_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry;
    logic       strobe;
    logic       stop;
    logic       ser_bit;
    logic [7:0] ser_q = 8'h00;
    logic       den;
    logic       lpdt;
    logic       ulps;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] trig;
    logic       err;
    logic       err_sync;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    esc_rx_ctrl dut (
        .RxClkEsc    (clk),
        .RstN        (rst_n),
        .EscEntryDet (entry),
        .BitStrobe   (strobe),
        .StopDet     (stop),
        .RxEscData   (ser_q),
        .EscDeserEn  (den),
        .RxLpdtEsc   (lpdt),
        .RxUlpsEsc   (ulps),
        .RxDataEsc   (rx_data),
        .RxValidEsc  (rx_valid),
        .RxTriggerEsc(trig),
        .ErrEsc      (err),
        .ErrSyncEsc  (err_sync),
        .dbg_state   (dbg_state)
    );

    // Deserializer model: LSB is the first bit received.
    always @(posedge clk) begin
        if (den) ser_q <= {ser_bit, ser_q[7:1]};
    end

    // Pulse monitor: counts pulses and collects delivered bytes.
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         errsync_cnt = 0;
    int         trig_cnt[4] = '{0, 0, 0, 0};
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                valid_cnt++;
                got_q.push_back(rx_data);
            end
            if (err) err_cnt++;
            if (err_sync) errsync_cnt++;
            for (int k = 0; k < 4; k++) if (trig[k]) trig_cnt[k]++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic       obs_den, obs_lpdt, obs_ulps, obs_valid, obs_err, obs_errsync;
    logic [3:0] obs_trig;
    logic [7:0] obs_data;

    // Drive one cycle (called at posedge+1), snapshot outputs mid-cycle.
    task automatic drive_cycle(input logic e, input logic s, input logic b, input logic p);
        entry = e; strobe = s; ser_bit = b; stop = p;
        @(negedge clk);
        obs_den = den; obs_lpdt = lpdt; obs_ulps = ulps; obs_valid = rx_valid;
        obs_err = err; obs_errsync = err_sync; obs_trig = trig; obs_data = rx_data;
        @(posedge clk);
        #1;
        entry = 1'b0; strobe = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_max);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, gap_max));
            drive_cycle(1'b0, 1'b1, v[i], 1'b0);
        end
    endtask

    task automatic start_cmd(input logic [7:0] c, input int gap_max);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(c, gap_max);
    endtask

    // Reference classification of an entry command: 0 unknown, 1 LPDT, 2 ULPS, 3+n trigger n.
    function automatic int kind_of(input logic [7:0] c);
        case (c)
            8'h87: return 1;
            8'h78: return 2;
            8'h46: return 3;
            8'h5D: return 4;
            8'hA2: return 5;
            8'hB9: return 6;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        logic [7:0] cmd;
        logic       lpdt;
        logic       ulps;
        logic [3:0] trig;
        logic       err;
    } vec_t;

    vec_t vecs[10];

    task automatic rand_session();
        logic [7:0] c;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        int         sel, kind, nbytes, extra, v0, e0, s0, r0, t0[4];
        logic       sb;
        sel = $urandom_range(0, 6);
        case (sel)
            0: c = 8'h87;
            1: c = 8'h78;
            2: c = 8'h46;
            3: c = 8'h5D;
            4: c = 8'hA2;
            5: c = 8'hB9;
            default: c = 8'($urandom_range(0, 255));
        endcase
        kind = kind_of(c);
        v0 = valid_cnt; e0 = err_cnt; s0 = errsync_cnt; r0 = got_q.size(); t0 = trig_cnt;
        extra = 0;
        start_cmd(c, 2);
        idle(1);
        if (kind == 1) begin
            nbytes = $urandom_range(0, 3);
            for (int i = 0; i < nbytes; i++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                send_byte(b, 2);
            end
            extra = $urandom_range(0, 7);
            for (int i = 0; i < extra; i++) drive_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end else begin
            for (int i = 0; i < int'($urandom_range(0, 5)); i++)
                drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
            drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        sb = (extra != 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_cycle(1'b0, sb, 1'b1, 1'b1);
        idle(3);
        check("rnd_nbytes", 32'(valid_cnt - v0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (r0 + i < got_q.size()) check("rnd_byte", got_q[r0 + i], exp_q[i]);
        end
        check("rnd_errsync", 32'(errsync_cnt - s0), 32'((kind == 1 && extra != 0) ? 1 : 0));
        check("rnd_err", 32'(err_cnt - e0), 32'((kind == 0) ? 1 : 0));
        for (int k = 0; k < 4; k++)
            check("rnd_trig", 32'(trig_cnt[k] - t0[k]), 32'((kind == 3 + k) ? 1 : 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, s0, r0, t0[4];
        logic all_ok;

        vecs[0] = '{8'h87, 1'b1, 1'b0, 4'b0000, 1'b0};
        vecs[1] = '{8'h78, 1'b0, 1'b1, 4'b0000, 1'b0};
        vecs[2] = '{8'h46, 1'b0, 1'b0, 4'b0001, 1'b0};
        vecs[3] = '{8'h5D, 1'b0, 1'b0, 4'b0010, 1'b0};
        vecs[4] = '{8'hA2, 1'b0, 1'b0, 4'b0100, 1'b0};
        vecs[5] = '{8'hB9, 1'b0, 1'b0, 4'b1000, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 4'b0000, 1'b1};
        vecs[7] = '{8'h00, 1'b0, 1'b0, 4'b0000, 1'b1};
        vecs[8] = '{8'hFF, 1'b0, 1'b0, 4'b0000, 1'b1};
        vecs[9] = '{8'h86, 1'b0, 1'b0, 4'b0000, 1'b1};

        // Clock/reset
        rst_n = 1'b0; entry = 1'b0; strobe = 1'b0; stop = 1'b0; ser_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lpdt", lpdt, 0);
        check("rst_ulps", ulps, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_pulses", {trig, err, err_sync}, 0);
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("idle_den", obs_den, 0);

        // Command table
        for (int i = 0; i < 10; i++) begin
            e0 = err_cnt; t0 = trig_cnt;
            start_cmd(vecs[i].cmd, 0);
            check("tbl_den_cmd", obs_den, 1);
            idle(1);
            check("tbl_trig", obs_trig, vecs[i].trig);
            check("tbl_err", obs_err, vecs[i].err);
            drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
            check("tbl_den_mode", obs_den, vecs[i].lpdt);
            check("tbl_lpdt", obs_lpdt, vecs[i].lpdt);
            check("tbl_ulps", obs_ulps, vecs[i].ulps);
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check("tbl_errsync", obs_errsync, vecs[i].lpdt);
            idle(1);
            check("tbl_mode_clr", {obs_lpdt, obs_ulps}, 0);
            check("tbl_err_once", 32'(err_cnt - e0), 32'(vecs[i].err));
            check("tbl_trig_once", 32'((trig_cnt[0] - t0[0]) + (trig_cnt[1] - t0[1]) +
                                        (trig_cnt[2] - t0[2]) + (trig_cnt[3] - t0[3])),
                  32'((vecs[i].trig != 0) ? 1 : 0));
        end

        // LPDT with two bytes, checking delivery latency
        v0 = valid_cnt; r0 = got_q.size(); s0 = errsync_cnt;
        start_cmd(8'h87, 0);
        idle(1);
        send_byte(8'hAB, 0);
        check("lpdt_mode", obs_lpdt, 1);
        idle(1);
        check("lpdt_valid_early", obs_valid, 0);
        idle(1);
        check("lpdt_valid", obs_valid, 1);
        check("lpdt_data0", obs_data, 8'hAB);
        send_byte(8'hF0, 2);
        idle(2);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("lpdt_at_stop", obs_lpdt, 1);
        idle(1);
        check("lpdt_clr", obs_lpdt, 0);
        check("lpdt_nbytes", 32'(valid_cnt - v0), 2);
        if (got_q.size() >= r0 + 2) check("lpdt_data1", got_q[r0 + 1], 8'hF0);
        check("lpdt_no_errsync", 32'(errsync_cnt - s0), 0);

        // ULPS hold with strobes ignored
        start_cmd(8'h78, 1);
        idle(2);
        all_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            if (!obs_ulps || obs_den) all_ok = 1'b0;
        end
        check("ulps_hold", all_ok, 1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("ulps_at_stop", obs_ulps, 1);
        idle(1);
        check("ulps_clr", obs_ulps, 0);

        // Unknown command then strobes in WAIT_STOP
        e0 = err_cnt; v0 = valid_cnt;
        start_cmd(8'h3C, 0);
        all_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (i > 0 && (obs_den || obs_lpdt || obs_ulps)) all_ok = 1'b0;
        end
        check("wait_quiet", all_ok, 1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("wait_err_once", 32'(err_cnt - e0), 1);
        check("wait_no_valid", 32'(valid_cnt - v0), 0);

        // Partial LPDT byte at Stop, then fresh command decode
        v0 = valid_cnt; s0 = errsync_cnt; t0 = trig_cnt;
        start_cmd(8'h87, 0);
        idle(1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("partial_errsync", obs_errsync, 1);
        idle(3);
        check("partial_errsync_once", 32'(errsync_cnt - s0), 1);
        check("partial_no_valid", 32'(valid_cnt - v0), 0);
        start_cmd(8'h46, 0);
        idle(1);
        check("fresh_trig", obs_trig, 4'b0001);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Stop coinciding with a strobe mid-command aborts entry quietly
        e0 = err_cnt;
        start_cmd(8'h87, 0);
        idle(1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("abort_den", obs_den, 1);
        idle(1);
        check("abort_no_err", 32'(err_cnt - e0), 0);
        start_cmd(8'h78, 0);
        idle(2);
        check("abort_then_ulps", obs_ulps, 1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Asynchronous reset mid-byte
        start_cmd(8'h87, 0);
        idle(1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_lpdt", lpdt, 0);
        check("arst_data", rx_data, 8'h00);
        check("arst_pulses", {rx_valid, trig, err, err_sync, ulps}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("arst_den", obs_den, 0);
        check("arst_idle", obs_lpdt, 0);

        // Randomized sessions
        for (int i = 0; i < 60; i++) rand_session();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
